// File: rtl/bfly12_stream_out_pkg.sv
// fft_stream_pkg: shared frame geometry, sample/index types, the stream FSM
// state type and the bit-reversal helper used by the frame output streamer.
// Ports: none (package).
package fft_stream_pkg;

    localparam int unsigned TOTAL_SIZE = 512;
    localparam int unsigned WIDTH      = 12;
    localparam int unsigned IDX_WIDTH  = 5;
    localparam int unsigned LANES      = 16;
    localparam int unsigned BEATS      = TOTAL_SIZE / LANES;
    localparam int unsigned ADDR_W     = $clog2(TOTAL_SIZE);
    localparam int unsigned LANE_W     = $clog2(LANES);
    localparam int unsigned BEAT_W     = $clog2(BEATS);

    typedef logic signed [WIDTH-1:0] sample_t;
    typedef logic [IDX_WIDTH-1:0]    idx_t;
    typedef logic [ADDR_W-1:0]       addr_t;
    typedef logic [BEAT_W-1:0]       beat_t;

    typedef enum logic {S_IDLE, S_STREAM} stream_state_t;

    // Reverse the ADDR_W bits of a sample address.
    function automatic addr_t bitrev(input addr_t addr);
        return {<<{addr}};
    endfunction

endpackage

// File: rtl/bfly12_stream_out_if.sv
// bfly12_stream_out_if: output beat stream of the frame streamer.
// Signals:
//   dout_valid             beat present
//   dout_ready             consumer accepts beat
//   dout_i / dout_q        LANES signed samples of the beat
//   dout_idx_re/_im        CBFP index for each lane
//   dout_beat              beat number 0..BEATS-1
//   dout_last              set on the final beat of a frame
// Modports: master (streamer side), slave (consumer side).
interface bfly12_stream_out_if;
    import fft_stream_pkg::*;

    logic    dout_valid;
    logic    dout_ready;
    sample_t dout_i      [0:LANES-1];
    sample_t dout_q      [0:LANES-1];
    idx_t    dout_idx_re [0:LANES-1];
    idx_t    dout_idx_im [0:LANES-1];
    beat_t   dout_beat;
    logic    dout_last;

    modport master (
        output dout_valid, dout_i, dout_q, dout_idx_re, dout_idx_im,
               dout_beat, dout_last,
        input  dout_ready
    );

    modport slave (
        input  dout_valid, dout_i, dout_q, dout_idx_re, dout_idx_im,
               dout_beat, dout_last,
        output dout_ready
    );

endinterface

// File: rtl/bfly_frame_buf.sv
// bfly_frame_buf: TOTAL_SIZE-entry register bank holding one frame of I/Q
// samples plus CBFP indices, written in full when cap_en is high, with a
// LANES-wide read port selected by beat number.
// Ports:
//   clk                      clock, rising edge
//   cap_en                   load the whole frame from din_*/idx_*
//   din_i/din_q/idx_re/idx_im frame to capture
//   rd_beat                  beat whose lanes appear on rd_*
//   rd_i/rd_q/rd_re/rd_im    LANES entries of the selected beat
// BIT_REV=1 maps lane l of beat b to sample bitrev(b*LANES+l).
module bfly_frame_buf
    import fft_stream_pkg::*;
#(
    parameter bit BIT_REV = 1'b0
) (
    input  logic    clk,
    input  logic    cap_en,
    input  sample_t din_i  [0:TOTAL_SIZE-1],
    input  sample_t din_q  [0:TOTAL_SIZE-1],
    input  idx_t    idx_re [0:TOTAL_SIZE-1],
    input  idx_t    idx_im [0:TOTAL_SIZE-1],
    input  beat_t   rd_beat,
    output sample_t rd_i   [0:LANES-1],
    output sample_t rd_q   [0:LANES-1],
    output idx_t    rd_re  [0:LANES-1],
    output idx_t    rd_im  [0:LANES-1]
);

    sample_t mem_i  [0:TOTAL_SIZE-1];
    sample_t mem_q  [0:TOTAL_SIZE-1];
    idx_t    mem_re [0:TOTAL_SIZE-1];
    idx_t    mem_im [0:TOTAL_SIZE-1];
    addr_t   rd_addr [0:LANES-1];

    // Contents are don't-care after reset, so the bank carries no reset.
    always_ff @(posedge clk) begin
        if (cap_en) begin
            mem_i  <= din_i;
            mem_q  <= din_q;
            mem_re <= idx_re;
            mem_im <= idx_im;
        end
    end

    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            rd_addr[l] = BIT_REV ? bitrev({rd_beat, LANE_W'(l)})
                                 : {rd_beat, LANE_W'(l)};
        end
    end

    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            rd_i[l]  = mem_i[rd_addr[l]];
            rd_q[l]  = mem_q[rd_addr[l]];
            rd_re[l] = mem_re[rd_addr[l]];
            rd_im[l] = mem_im[rd_addr[l]];
        end
    end

endmodule

// File: rtl/bfly12_stream_out.sv
// bfly12_stream_out: captures a complete stage-1 frame on a valid_in pulse
// and streams it out as BEATS beats of LANES samples under valid/ready.
// Ports:
//   clk        clock, rising edge
//   rstn       asynchronous reset, active high
//   valid_in   one-cycle pulse, din_*/idx_* hold a complete frame
//   din_i/din_q, idx_re/idx_im   frame samples and CBFP indices
//   busy       frame held and not yet fully streamed
//   overflow   sticky, a frame arrived while busy and was dropped
//   frame_cnt  frames fully streamed, wraps at 2^16
//   dout       output beat stream (master side)
module bfly12_stream_out
    import fft_stream_pkg::*;
#(
    parameter bit BIT_REV = 1'b0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       valid_in,
    input  sample_t                    din_i  [0:TOTAL_SIZE-1],
    input  sample_t                    din_q  [0:TOTAL_SIZE-1],
    input  idx_t                       idx_re [0:TOTAL_SIZE-1],
    input  idx_t                       idx_im [0:TOTAL_SIZE-1],
    output logic                       busy,
    output logic                       overflow,
    output logic [15:0]                frame_cnt,
    bfly12_stream_out_if.master        dout
);

    stream_state_t state, state_nx;
    beat_t         beat, beat_nx;
    logic          accept, last_hs, capture, drop;

    sample_t rd_i  [0:LANES-1];
    sample_t rd_q  [0:LANES-1];
    idx_t    rd_re [0:LANES-1];
    idx_t    rd_im [0:LANES-1];

    bfly_frame_buf #(
        .BIT_REV (BIT_REV)
    ) u_buf (
        .clk     (clk),
        .cap_en  (capture),
        .din_i   (din_i),
        .din_q   (din_q),
        .idx_re  (idx_re),
        .idx_im  (idx_im),
        .rd_beat (beat),
        .rd_i    (rd_i),
        .rd_q    (rd_q),
        .rd_re   (rd_re),
        .rd_im   (rd_im)
    );

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state     <= S_IDLE;
            beat      <= '0;
            frame_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nx;
            beat  <= beat_nx;
            if (last_hs) frame_cnt <= frame_cnt + 16'd1;
            if (drop)    overflow  <= 1'b1;
        end
    end

    // A new frame is taken when idle or exactly on the last-beat handshake,
    // which lets back-to-back frames stream without an idle cycle.
    always_comb begin
        state_nx = state;
        beat_nx  = beat;
        accept   = (state == S_STREAM) && dout.dout_ready;
        last_hs  = accept && (beat == beat_t'(BEATS - 1));
        capture  = valid_in && ((state == S_IDLE) || last_hs);
        drop     = valid_in && (state == S_STREAM) && !last_hs;

        unique case (state)
            S_IDLE: begin
                if (valid_in) begin
                    state_nx = S_STREAM;
                    beat_nx  = '0;
                end
            end
            S_STREAM: begin
                if (last_hs) begin
                    beat_nx  = '0;
                    state_nx = valid_in ? S_STREAM : S_IDLE;
                end else if (accept) begin
                    beat_nx = beat + 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                beat_nx  = '0;
            end
        endcase
    end

    // Beat data is a mux over flops (buffer bank and beat register); it only
    // moves when the beat advances, so it holds across stalls. Zeroed when idle.
    always_comb begin
        busy            = (state == S_STREAM);
        dout.dout_valid = busy;
        dout.dout_beat  = beat;
        dout.dout_last  = busy && (beat == beat_t'(BEATS - 1));
        for (int unsigned l = 0; l < LANES; l++) begin
            dout.dout_i[l]      = busy ? rd_i[l]  : '0;
            dout.dout_q[l]      = busy ? rd_q[l]  : '0;
            dout.dout_idx_re[l] = busy ? rd_re[l] : '0;
            dout.dout_idx_im[l] = busy ? rd_im[l] : '0;
        end
    end

endmodule

// File: tb/tb_bfly12_stream_out.sv
// tb_bfly12_stream_out: randomized self-checking bench for bfly12_stream_out.
// Two instances share inputs: dut (natural order) and dut_rev (bit-reversed).
module tb_bfly12_stream_out;
    import fft_stream_pkg::*;

    localparam int NT = TOTAL_SIZE;
    localparam int NL = LANES;
    localparam int NB = BEATS;
    localparam int AW = ADDR_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        valid_in0, valid_in1;
    sample_t     din_i  [0:NT-1];
    sample_t     din_q  [0:NT-1];
    idx_t        idx_re [0:NT-1];
    idx_t        idx_im [0:NT-1];
    logic        busy0, busy1, ovf0, ovf1;
    logic [15:0] fcnt0, fcnt1;

    bfly12_stream_out_if bus0 ();
    bfly12_stream_out_if bus1 ();

    bfly12_stream_out #(.BIT_REV(1'b0)) dut (
        .clk(clk), .rstn(rstn), .valid_in(valid_in0),
        .din_i(din_i), .din_q(din_q), .idx_re(idx_re), .idx_im(idx_im),
        .busy(busy0), .overflow(ovf0), .frame_cnt(fcnt0), .dout(bus0)
    );

    bfly12_stream_out #(.BIT_REV(1'b1)) dut_rev (
        .clk(clk), .rstn(rstn), .valid_in(valid_in1),
        .din_i(din_i), .din_q(din_q), .idx_re(idx_re), .idx_im(idx_im),
        .busy(busy1), .overflow(ovf1), .frame_cnt(fcnt1), .dout(bus1)
    );

    int checks   = 0;
    int failures = 0;

    // Reference frames
    sample_t f_i  [0:1][0:NT-1];
    sample_t f_q  [0:1][0:NT-1];
    idx_t    f_re [0:1][0:NT-1];
    idx_t    f_im [0:1][0:NT-1];

    // Sampled DUT view
    logic    s_valid, s_last, s_busy, s_ovf;
    int      s_beat, s_fcnt;
    sample_t s_i  [0:NL-1];
    sample_t s_q  [0:NL-1];
    idx_t    s_re [0:NL-1];
    idx_t    s_im [0:NL-1];

    // Accepted beats
    sample_t g_i  [0:63][0:NL-1];
    sample_t g_q  [0:63][0:NL-1];
    idx_t    g_re [0:63][0:NL-1];
    idx_t    g_im [0:63][0:NL-1];
    int      g_beat [0:63];
    logic    g_last [0:63];
    int      hold_err;

    // Sample index carried by lane l of beat b.
    function automatic int ref_addr(input int rev, input int b, input int l);
        int a, r;
        a = b * NL + l;
        if (rev == 0) return a;
        r = 0;
        for (int j = 0; j < AW; j++) begin
            r = r * 2 + (a % 2);
            a = a / 2;
        end
        return r;
    endfunction

    // Mismatches between collected beats and frames base, base+1, ...
    function automatic int stream_errs(input int rev, input int n_beats, input int base);
        int e, fr, b, a;
        e = 0;
        for (int n = 0; n < n_beats; n++) begin
            fr = base + n / NB;
            b  = n % NB;
            if (g_beat[n] != b) e++;
            if (g_last[n] !== (b == NB - 1)) e++;
            for (int l = 0; l < NL; l++) begin
                a = ref_addr(rev, b, l);
                if (g_i[n][l]  !== f_i[fr][a])  e++;
                if (g_q[n][l]  !== f_q[fr][a])  e++;
                if (g_re[n][l] !== f_re[fr][a]) e++;
                if (g_im[n][l] !== f_im[fr][a]) e++;
            end
        end
        return e;
    endfunction

    task automatic fill_ramp(input int sel);
        for (int k = 0; k < NT; k++) begin
            f_i[sel][k]  = sample_t'(k);
            f_q[sel][k]  = sample_t'(-k);
            f_re[sel][k] = idx_t'(k % 32);
            f_im[sel][k] = idx_t'(k % 32);
        end
    endtask

    task automatic fill_random(input int sel);
        for (int k = 0; k < NT; k++) begin
            f_i[sel][k]  = sample_t'($urandom);
            f_q[sel][k]  = sample_t'($urandom);
            f_re[sel][k] = idx_t'($urandom);
            f_im[sel][k] = idx_t'($urandom);
        end
    endtask

    task automatic fill_extreme(input int sel);
        for (int k = 0; k < NT; k++) begin
            f_i[sel][k]  = (k % 2 == 0) ? -12'sd2048 : 12'sd2047;
            f_q[sel][k]  = (k % 2 == 0) ? 12'sd2047 : -12'sd2048;
            f_re[sel][k] = 5'd31;
            f_im[sel][k] = 5'd31;
        end
    endtask

    task automatic drive_frame(input int sel);
        for (int k = 0; k < NT; k++) begin
            din_i[k]  = f_i[sel][k];
            din_q[k]  = f_q[sel][k];
            idx_re[k] = f_re[sel][k];
            idx_im[k] = f_im[sel][k];
        end
    endtask

    task automatic set_valid(input int which, input logic v);
        if (which == 0) valid_in0 = v; else valid_in1 = v;
    endtask

    task automatic set_ready(input int which, input logic r);
        if (which == 0) bus0.dout_ready = r; else bus1.dout_ready = r;
    endtask

    task automatic sample(input int which);
        if (which == 0) begin
            s_valid = bus0.dout_valid; s_last = bus0.dout_last;
            s_beat  = int'(bus0.dout_beat); s_busy = busy0;
            s_ovf   = ovf0; s_fcnt = int'(fcnt0);
            for (int l = 0; l < NL; l++) begin
                s_i[l] = bus0.dout_i[l];  s_q[l]  = bus0.dout_q[l];
                s_re[l] = bus0.dout_idx_re[l]; s_im[l] = bus0.dout_idx_im[l];
            end
        end else begin
            s_valid = bus1.dout_valid; s_last = bus1.dout_last;
            s_beat  = int'(bus1.dout_beat); s_busy = busy1;
            s_ovf   = ovf1; s_fcnt = int'(fcnt1);
            for (int l = 0; l < NL; l++) begin
                s_i[l] = bus1.dout_i[l];  s_q[l]  = bus1.dout_q[l];
                s_re[l] = bus1.dout_idx_re[l]; s_im[l] = bus1.dout_idx_im[l];
            end
        end
    endtask

    task automatic do_reset();
        rstn = 1'b1;
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic start_frame(input int which, input int sel);
        drive_frame(sel);
        set_valid(which, 1'b1);
        @(posedge clk); #1;
        set_valid(which, 1'b0);
    endtask

    // Drives ready (always 1 or random) and records accepted beats in g_*.
    // drop_at: pulse valid_in while showing that beat; chain: pulse valid_in
    // with frame 1 on the last-beat handshake of the first frame.
    task automatic run_stream(input int which, input int rnd_ready, input int max_beats,
                              input int drop_at, input int chain, input int budget,
                              output int nb, output int cyc, output int to, output int stalls);
        logic    r, vin, held, dropped;
        sample_t h_i [0:NL-1];
        sample_t h_q [0:NL-1];
        idx_t    h_re [0:NL-1];
        idx_t    h_im [0:NL-1];
        int      h_beat;
        nb = 0; cyc = 0; to = 0; stalls = 0; hold_err = 0;
        held = 1'b0; dropped = 1'b0; h_beat = 0;
        while (nb < max_beats) begin
            if (cyc >= budget) begin
                to = 1;
                break;
            end
            sample(which);
            r = (rnd_ready != 0) ? logic'($urandom_range(0, 1)) : 1'b1;
            set_ready(which, r);
            vin = 1'b0;
            if (drop_at >= 0 && !dropped && s_valid && s_beat == drop_at) begin
                vin = 1'b1; dropped = 1'b1; drive_frame(1);
            end
            if (chain != 0 && nb < NB && s_valid && r && s_beat == NB - 1) begin
                vin = 1'b1; drive_frame(1);
            end
            set_valid(which, vin);
            if (held) begin
                if (s_beat != h_beat) hold_err++;
                for (int l = 0; l < NL; l++)
                    if (s_i[l] !== h_i[l] || s_q[l] !== h_q[l] ||
                        s_re[l] !== h_re[l] || s_im[l] !== h_im[l]) hold_err++;
            end
            if (s_valid && r) begin
                g_beat[nb] = s_beat; g_last[nb] = s_last;
                for (int l = 0; l < NL; l++) begin
                    g_i[nb][l] = s_i[l]; g_q[nb][l] = s_q[l];
                    g_re[nb][l] = s_re[l]; g_im[nb][l] = s_im[l];
                end
                nb++;
                held = 1'b0;
            end else if (s_valid) begin
                stalls++;
                held = 1'b1; h_beat = s_beat;
                h_i = s_i; h_q = s_q; h_re = s_re; h_im = s_im;
            end
            @(posedge clk); #1;
            cyc++;
        end
        set_valid(which, 1'b0);
        set_ready(which, 1'b1);
    endtask

    task automatic test_reset();
        int z;
        for (int w = 0; w < 2; w++) begin
            sample(w);
            z = 0;
            for (int l = 0; l < NL; l++)
                if (s_i[l] !== '0 || s_q[l] !== '0 || s_re[l] !== '0 || s_im[l] !== '0) z++;
            checks++;
            if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_last !== 1'b0 || s_beat != 0 ||
                s_ovf !== 1'b0 || s_fcnt != 0 || z != 0) begin
                failures++;
                $display("FAIL reset_state dut%0d: valid=%b busy=%b last=%b beat=%0d ovf=%b fcnt=%0d nonzero_lanes=%0d, required all 0",
                         w, s_valid, s_busy, s_last, s_beat, s_ovf, s_fcnt, z);
            end
        end
        rstn = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ramp();
        int nb, cyc, to, st, e, z;
        do_reset();
        fill_ramp(0);
        start_frame(0, 0);
        sample(0);
        checks++;
        if (s_valid !== 1'b1 || s_beat != 0 || s_busy !== 1'b1) begin
            failures++;
            $display("FAIL ramp_latency: valid=%b beat=%0d busy=%b, required 1/0/1", s_valid, s_beat, s_busy);
        end
        run_stream(0, 0, NB, -1, 0, 100, nb, cyc, to, st);
        checks++;
        if (to != 0 || nb != NB || cyc != NB) begin
            failures++;
            $display("FAIL ramp_count: beats=%0d cycles=%0d timeout=%0d, required %0d/%0d/0", nb, cyc, to, NB, NB);
        end
        e = stream_errs(0, nb, 0);
        checks++;
        if (e != 0) begin
            failures++;
            $display("FAIL ramp_data: mismatches=%0d, required 0", e);
        end
        checks++;
        if (int'(g_i[5][3]) != 83 || int'(g_q[5][3]) != -83) begin
            failures++;
            $display("FAIL ramp_spot: beat5 lane3 i=%0d q=%0d, required 83/-83", g_i[5][3], g_q[5][3]);
        end
        sample(0);
        z = 0;
        for (int l = 0; l < NL; l++)
            if (s_i[l] !== '0 || s_q[l] !== '0 || s_re[l] !== '0 || s_im[l] !== '0) z++;
        checks++;
        if (s_busy !== 1'b0 || s_valid !== 1'b0 || s_fcnt != 1 || s_ovf !== 1'b0 || s_beat != 0 || z != 0) begin
            failures++;
            $display("FAIL ramp_end: busy=%b valid=%b fcnt=%0d ovf=%b beat=%0d nonzero_lanes=%0d, required 0/0/1/0/0/0",
                     s_busy, s_valid, s_fcnt, s_ovf, s_beat, z);
        end
    endtask

    task automatic test_stall();
        int nb, cyc, to, st, e;
        do_reset();
        fill_ramp(0);
        start_frame(0, 0);
        run_stream(0, 1, NB, -1, 0, 1000, nb, cyc, to, st);
        checks++;
        if (to != 0 || nb != NB) begin
            failures++;
            $display("FAIL stall_count: beats=%0d timeout=%0d, required %0d/0", nb, to, NB);
        end
        checks++;
        if (hold_err != 0 || st == 0) begin
            failures++;
            $display("FAIL stall_hold: hold_changes=%0d stalls=%0d, required 0 and >0", hold_err, st);
        end
        e = stream_errs(0, nb, 0);
        checks++;
        if (e != 0) begin
            failures++;
            $display("FAIL stall_data: mismatches=%0d, required 0", e);
        end
        sample(0);
        checks++;
        if (s_fcnt != 1 || s_busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_end: fcnt=%0d busy=%b, required 1/0", s_fcnt, s_busy);
        end
    endtask

    task automatic test_bitrev();
        int nb, cyc, to, st, e;
        int exp4 [0:3];
        exp4 = '{0, 256, 128, 384};
        do_reset();
        fill_ramp(0);
        start_frame(1, 0);
        sample(1);
        for (int l = 0; l < 4; l++) begin
            checks++;
            if (int'(s_i[l]) != exp4[l]) begin
                failures++;
                $display("FAIL bitrev_beat0 lane%0d: got %0d, required %0d", l, s_i[l], exp4[l]);
            end
        end
        run_stream(1, 1, NB, -1, 0, 1000, nb, cyc, to, st);
        e = stream_errs(1, nb, 0);
        checks++;
        if (to != 0 || nb != NB || e != 0 || hold_err != 0) begin
            failures++;
            $display("FAIL bitrev_stream: beats=%0d timeout=%0d mismatches=%0d hold=%0d, required %0d/0/0/0",
                     nb, to, e, hold_err, NB);
        end
    endtask

    task automatic test_back_to_back();
        int nb, cyc, to, st, e;
        // chained frames, nothing dropped
        do_reset();
        fill_random(0);
        fill_random(1);
        start_frame(0, 0);
        run_stream(0, 0, 2 * NB, -1, 1, 200, nb, cyc, to, st);
        e = stream_errs(0, nb, 0);
        sample(0);
        checks++;
        if (to != 0 || nb != 2 * NB || cyc != 2 * NB || e != 0) begin
            failures++;
            $display("FAIL chain_stream: beats=%0d cycles=%0d timeout=%0d mismatches=%0d, required %0d/%0d/0/0",
                     nb, cyc, to, e, 2 * NB, 2 * NB);
        end
        checks++;
        if (s_fcnt != 2 || s_ovf !== 1'b0 || s_busy !== 1'b0) begin
            failures++;
            $display("FAIL chain_end: fcnt=%0d ovf=%b busy=%b, required 2/0/0", s_fcnt, s_ovf, s_busy);
        end
        // drop at beat 10, then chain on the last beat
        do_reset();
        fill_random(0);
        fill_random(1);
        start_frame(0, 0);
        run_stream(0, 0, 2 * NB, 10, 1, 200, nb, cyc, to, st);
        e = stream_errs(0, nb, 0);
        sample(0);
        checks++;
        if (to != 0 || nb != 2 * NB || cyc != 2 * NB || e != 0) begin
            failures++;
            $display("FAIL drop_stream: beats=%0d cycles=%0d timeout=%0d mismatches=%0d, required %0d/%0d/0/0",
                     nb, cyc, to, e, 2 * NB, 2 * NB);
        end
        checks++;
        if (s_ovf !== 1'b1 || s_fcnt != 2 || s_busy !== 1'b0) begin
            failures++;
            $display("FAIL drop_end: ovf=%b fcnt=%0d busy=%b, required 1/2/0", s_ovf, s_fcnt, s_busy);
        end
    endtask

    task automatic test_reset_mid();
        int nb, cyc, to, st, e, z;
        fill_random(0);
        fill_random(1);
        start_frame(0, 0);
        run_stream(0, 0, 20, -1, 0, 100, nb, cyc, to, st);
        sample(0);
        checks++;
        if (s_beat != 20 || s_valid !== 1'b1 || s_ovf !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre: beat=%0d valid=%b ovf=%b, required 20/1/1", s_beat, s_valid, s_ovf);
        end
        rstn = 1'b1;
        #1;
        @(posedge clk); #1;
        sample(0);
        z = 0;
        for (int l = 0; l < NL; l++)
            if (s_i[l] !== '0 || s_q[l] !== '0 || s_re[l] !== '0 || s_im[l] !== '0) z++;
        checks++;
        if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_beat != 0 || s_last !== 1'b0 ||
            s_ovf !== 1'b0 || s_fcnt != 0 || z != 0) begin
            failures++;
            $display("FAIL rstmid_zero: valid=%b busy=%b beat=%0d last=%b ovf=%b fcnt=%0d nonzero_lanes=%0d, required all 0",
                     s_valid, s_busy, s_beat, s_last, s_ovf, s_fcnt, z);
        end
        rstn = 1'b0;
        start_frame(0, 1);
        run_stream(0, 1, NB, -1, 0, 1000, nb, cyc, to, st);
        e = stream_errs(0, nb, 1);
        sample(0);
        checks++;
        if (to != 0 || nb != NB || e != 0 || s_fcnt != 1 || s_ovf !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_fresh: beats=%0d timeout=%0d mismatches=%0d fcnt=%0d ovf=%b, required %0d/0/0/1/0",
                     nb, to, e, s_fcnt, s_ovf, NB);
        end
    endtask

    task automatic test_extremes();
        int nb, cyc, to, st, e;
        do_reset();
        fill_extreme(0);
        start_frame(0, 0);
        run_stream(0, 0, NB, -1, 0, 100, nb, cyc, to, st);
        e = stream_errs(0, nb, 0);
        checks++;
        if (to != 0 || nb != NB || e != 0) begin
            failures++;
            $display("FAIL extreme_stream: beats=%0d timeout=%0d mismatches=%0d, required %0d/0/0", nb, to, e, NB);
        end
        checks++;
        if (g_i[0][0] !== -12'sd2048 || g_i[0][1] !== 12'sd2047 ||
            g_q[0][0] !== 12'sd2047 || g_re[0][0] !== 5'd31 || g_im[31][15] !== 5'd31) begin
            failures++;
            $display("FAIL extreme_spot: i0=%0d i1=%0d q0=%0d re=%0d im=%0d, required -2048/2047/2047/31/31",
                     g_i[0][0], g_i[0][1], g_q[0][0], g_re[0][0], g_im[31][15]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b1;
        valid_in0 = 1'b0;
        valid_in1 = 1'b0;
        bus0.dout_ready = 1'b1;
        bus1.dout_ready = 1'b1;
        for (int k = 0; k < NT; k++) begin
            din_i[k] = '0; din_q[k] = '0; idx_re[k] = '0; idx_im[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_ramp();
        test_stall();
        test_bitrev();
        test_back_to_back();
        test_reset_mid();
        test_extremes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
